// File: rtl/satagtx_pkg.sv
// Shared definitions for the SATA GTX tile-0 reset sequencer:
// state width, state encodings and a small constant helper.
package satagtx_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_GTXRST    = 3'd0;
  localparam logic [STATE_W-1:0] S_WAIT_PLL  = 3'd1;
  localparam logic [STATE_W-1:0] S_WAIT_DCM  = 3'd2;
  localparam logic [STATE_W-1:0] S_USRRST    = 3'd3;
  localparam logic [STATE_W-1:0] S_WAIT_DONE = 3'd4;
  localparam logic [STATE_W-1:0] S_READY     = 3'd5;
  localparam logic [STATE_W-1:0] S_FAIL      = 3'd6;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/satagtx_sync.sv
// Two-flop synchronizer for a single asynchronous level; output resets to 0.
module satagtx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/satagtx_rst_seq.sv
// GTX tile-0 reset and bring-up sequencer for the SATA PHY.
// Define SATAGTX_RST_RETRY_EN to tolerate timeouts (up to C_MAX_RETRIES) before FAIL.
module satagtx_rst_seq
  import satagtx_pkg::*;
#(
  parameter string C_FAMILY            = "none",
  parameter int    C_RESET_HOLD_CYCLES = 16,
  parameter int    C_TIMEOUT_CYCLES    = 65536,
  parameter int    C_MAX_RETRIES       = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tile0_plllkdet,
  input  logic               refclkout_dcm0_locked,
  input  logic               tile0_resetdone0,
  input  logic               tile0_resetdone1,
  input  logic               phy_reinit,
  output logic               tile0_gtxreset,
  output logic               tile0_txreset0,
  output logic               tile0_rxreset0,
  output logic               tile0_rxcdrreset0,
  output logic               phy_ready,
  output logic               phy_fail,
  output logic [STATE_W-1:0] seq_state,
  output logic [3:0]         retry_cnt
);

  localparam int CNT_W = $clog2(max_int(C_TIMEOUT_CYCLES, C_RESET_HOLD_CYCLES));
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(C_RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(C_TIMEOUT_CYCLES - 1);

  // An out-of-range build elaborates g_bad_params, which is easy to spot in a hierarchy dump.
  localparam bit PARAMS_OK = (C_FAMILY != "") && (C_RESET_HOLD_CYCLES >= 2) &&
                             (C_TIMEOUT_CYCLES >= 4) && (C_MAX_RETRIES >= 1) &&
                             (C_MAX_RETRIES <= 15);
  if (!PARAMS_OK) begin : g_bad_params
  end

  logic w_pll_s;
  logic w_dcm_s;
  logic w_done0_s;
  logic w_done1_s;

  satagtx_sync u_sync_pll   (.clk(clk), .rst(rst), .i_async(tile0_plllkdet),        .o_sync(w_pll_s));
  satagtx_sync u_sync_dcm   (.clk(clk), .rst(rst), .i_async(refclkout_dcm0_locked), .o_sync(w_dcm_s));
  satagtx_sync u_sync_done0 (.clk(clk), .rst(rst), .i_async(tile0_resetdone0),      .o_sync(w_done0_s));
  satagtx_sync u_sync_done1 (.clk(clk), .rst(rst), .i_async(tile0_resetdone1),      .o_sync(w_done1_s));

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_timeout;
  logic               r_gtxrst;
  logic               r_usrrst;
  logic               r_ready;
  logic               r_fail;

`ifdef SATAGTX_RST_RETRY_EN
  logic [3:0] r_retry;
  logic [4:0] w_retry_inc;

  assign w_retry_inc = {1'b0, r_retry} + 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retry <= 4'd0;
    end else if ((w_next_state == S_READY) && (r_state != S_READY)) begin
      r_retry <= 4'd0;
    end else if (w_timeout && (w_next_state == S_GTXRST) && (r_retry != 4'hF)) begin
      r_retry <= w_retry_inc[3:0];
    end
  end

  assign retry_cnt = r_retry;
`else
  assign retry_cnt = 4'd0;
`endif

  // Lock loss outranks everything, then DCM loss, then the awaited condition, then timeout.
  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      S_GTXRST: begin
        if (r_cnt == HOLD_LAST) w_next_state = S_WAIT_PLL;
      end
      S_WAIT_PLL: begin
        if (w_pll_s)                w_next_state = S_WAIT_DCM;
        else if (r_cnt == TO_LAST)  w_timeout    = 1'b1;
      end
      S_WAIT_DCM: begin
        if (!w_pll_s)               w_next_state = S_GTXRST;
        else if (w_dcm_s)           w_next_state = S_USRRST;
        else if (r_cnt == TO_LAST)  w_timeout    = 1'b1;
      end
      S_USRRST: begin
        if (!w_pll_s)                w_next_state = S_GTXRST;
        else if (r_cnt == HOLD_LAST) w_next_state = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!w_pll_s)                    w_next_state = S_GTXRST;
        else if (!w_dcm_s)               w_next_state = S_WAIT_DCM;
        else if (w_done0_s && w_done1_s) w_next_state = S_READY;
        else if (r_cnt == TO_LAST)       w_timeout    = 1'b1;
      end
      S_READY: begin
        if (!w_pll_s)        w_next_state = S_GTXRST;
        else if (!w_dcm_s)   w_next_state = S_WAIT_DCM;
        else if (phy_reinit) w_next_state = S_USRRST;
      end
      default: w_next_state = S_FAIL;
    endcase

    if (w_timeout) begin
`ifdef SATAGTX_RST_RETRY_EN
      if (w_retry_inc == 5'(C_MAX_RETRIES)) w_next_state = S_FAIL;
      else                                  w_next_state = S_GTXRST;
`else
      w_next_state = S_FAIL;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Outputs are registered from the next state so they change on the same edge as seq_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_GTXRST;
      r_gtxrst <= 1'b1;
      r_usrrst <= 1'b1;
      r_ready  <= 1'b0;
      r_fail   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_gtxrst <= (w_next_state == S_GTXRST);
      r_ready  <= (w_next_state == S_READY);
      r_fail   <= (w_next_state == S_FAIL);
      if ((w_next_state == S_GTXRST) || (w_next_state == S_USRRST)) begin
        r_usrrst <= 1'b1;
      end else if (w_next_state == S_WAIT_DONE) begin
        r_usrrst <= 1'b0;
      end
    end
  end

  assign seq_state         = r_state;
  assign tile0_gtxreset    = r_gtxrst;
  assign tile0_txreset0    = r_usrrst;
  assign tile0_rxreset0    = r_usrrst;
  assign tile0_rxcdrreset0 = r_usrrst;
  assign phy_ready         = r_ready;
  assign phy_fail          = r_fail;

endmodule

// File: tb/tb_satagtx_rst_seq.sv
// Self-checking bench for satagtx_rst_seq: directed bring-up scenarios plus a random
// soak, every cycle compared against a phase/dwell reference model.
module tb_satagtx_rst_seq;

  localparam int HOLD    = 4;
  localparam int TIMEOUT = 64;
  localparam int RETRIES = 2;
`ifdef SATAGTX_RST_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       pll, dcm, done0, done1, reinit;
  logic       gtxReset, txReset, rxReset, cdrReset;
  logic       phyReady, phyFail;
  logic [2:0] seqState;
  logic [3:0] retryCnt;

  always #5 clk = ~clk;

  satagtx_rst_seq #(
    .C_FAMILY           ("none"),
    .C_RESET_HOLD_CYCLES(HOLD),
    .C_TIMEOUT_CYCLES   (TIMEOUT),
    .C_MAX_RETRIES      (RETRIES)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .tile0_plllkdet       (pll),
    .refclkout_dcm0_locked(dcm),
    .tile0_resetdone0     (done0),
    .tile0_resetdone1     (done1),
    .phy_reinit           (reinit),
    .tile0_gtxreset       (gtxReset),
    .tile0_txreset0       (txReset),
    .tile0_rxreset0       (rxReset),
    .tile0_rxcdrreset0    (cdrReset),
    .phy_ready            (phyReady),
    .phy_fail             (phyFail),
    .seq_state            (seqState),
    .retry_cnt            (retryCnt)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: phase number, cycles spent in it, timeouts since READY,
  // user-reset level, and a two-deep queue standing in for the synchronizers.
  int         mPhase;
  int         mDwell;
  int         mRetries;
  bit         mUsr;
  logic [3:0] syncQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPhase   = 0;
    mDwell   = 0;
    mRetries = 0;
    mUsr     = 1'b1;
    syncQ    = {4'b0000, 4'b0000};
  endtask

  task automatic modelStep();
    logic [3:0] seen;
    int         nxt;
    bit         lastHold, lastWait, expired;
    bit         sPll, sDcm, sDone;
    seen = syncQ.pop_front();
    syncQ.push_back({pll, dcm, done0, done1});
    sPll     = seen[3];
    sDcm     = seen[2];
    sDone    = seen[1] & seen[0];
    lastHold = (mDwell + 1 == HOLD);
    lastWait = (mDwell + 1 == TIMEOUT);
    nxt      = mPhase;
    expired  = 1'b0;
    case (mPhase)
      0: if (lastHold) nxt = 1;
      1: if (sPll) nxt = 2; else if (lastWait) expired = 1'b1;
      2: if (!sPll) nxt = 0; else if (sDcm) nxt = 3; else if (lastWait) expired = 1'b1;
      3: if (!sPll) nxt = 0; else if (lastHold) nxt = 4;
      4: if (!sPll) nxt = 0; else if (!sDcm) nxt = 2; else if (sDone) nxt = 5;
         else if (lastWait) expired = 1'b1;
      5: if (!sPll) nxt = 0; else if (!sDcm) nxt = 2; else if (reinit) nxt = 3;
      default: nxt = 6;
    endcase
    if (expired) begin
      if (RETRY_EN && (mRetries + 1 < RETRIES)) begin
        mRetries++;
        nxt = 0;
      end else begin
        nxt = 6;
      end
    end
    mDwell = (nxt != mPhase) ? 0 : mDwell + 1;
    if (nxt == 5) mRetries = 0;
    if (nxt == 0 || nxt == 3) mUsr = 1'b1;
    else if (nxt == 4) mUsr = 1'b0;
    mPhase = nxt;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) modelReset();
    else     modelStep();
  end

  task automatic checkCycle();
    checkOutput("seq_state", seqState, mPhase);
    checkOutput("gtxreset", gtxReset, (mPhase == 0));
    checkOutput("txreset", txReset, mUsr);
    checkOutput("rxreset", rxReset, mUsr);
    checkOutput("rxcdrreset", cdrReset, mUsr);
    checkOutput("phy_ready", phyReady, (mPhase == 5));
    checkOutput("phy_fail", phyFail, (mPhase == 6));
    checkOutput("retry_cnt", retryCnt, RETRY_EN ? mRetries : 0);
  endtask

  task automatic applyStimulus(input bit p, input bit d, input bit r0, input bit r1, input bit ri);
    pll    = p;
    dcm    = d;
    done0  = r0;
    done1  = r1;
    reinit = ri;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
    checkCycle();
  endtask

  // Called at a falling edge; outputs must take reset values without waiting for a clock.
  task automatic pulseReset(input int holdCycles);
    rst = 1'b1;
    #1;
    checkCycle();
    checkOutput("rst_async_ready", phyReady, 0);
    repeat (holdCycles) stepCycle();
    rst = 1'b0;
  endtask

  task automatic waitState(input int target, input int budget, input string tag);
    int n = 0;
    while ((seqState !== target[2:0]) && (n < budget)) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, seqState, target);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    repeat (2) begin
      @(negedge clk);
      checkCycle();
    end

    // Clean bring-up with the staggered lock schedule.
    rst = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      stepCycle();
      if (c == 3)  checkOutput("gtx_hold_c3", gtxReset, 1);
      if (c == 4)  checkOutput("gtx_hold_c4", gtxReset, 0);
      if (c == 26) checkOutput("usr_hold_c26", txReset, 1);
      if (c == 27) checkOutput("usr_hold_c27", txReset, 0);
      if (c == 42) checkOutput("ready_c42", phyReady, 0);
      if (c == 43) checkOutput("ready_c43", phyReady, 1);
      if (c == 43) checkOutput("ready_retry", retryCnt, 0);
      if (c == 10) pll = 1'b1;
      if (c == 20) dcm = 1'b1;
      if (c == 40) begin done0 = 1'b1; done1 = 1'b1; end
    end

    // One-cycle PLL glitch in READY.
    pll = 1'b0;
    stepCycle();
    pll = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("pll_loss_ready", phyReady, 0);
    checkOutput("pll_loss_gtx", gtxReset, 1);
    waitState(5, 200, "pll_loss_recover");

    // DCM drop in READY returns to WAIT_DCM without a GTX reset.
    dcm = 1'b0;
    repeat (3) stepCycle();
    checkOutput("dcm_loss_state", seqState, 2);
    checkOutput("dcm_loss_gtx", gtxReset, 0);
    repeat (5) stepCycle();
    dcm = 1'b1;
    waitState(3, 10, "dcm_relock_usr");
    waitState(5, 40, "dcm_relock_ready");

    // Reinit from READY re-runs only the user resets.
    reinit = 1'b1;
    stepCycle();
    reinit = 1'b0;
    checkOutput("reinit_state", seqState, 3);
    waitState(5, 40, "reinit_ready");

    // Reset pulse while waiting for reset-done.
    done0 = 1'b0;
    done1 = 1'b0;
    reinit = 1'b1;
    stepCycle();
    reinit = 1'b0;
    waitState(4, 20, "reach_wait_done");
    pulseReset(2);

    // PLL never locks: retries then sticky FAIL.
    applyStimulus(0, 0, 0, 0, 0);
    waitState(6, 400, "pll_timeout_fail");
    applyStimulus(1, 1, 1, 1, 0);
    for (int i = 0; i < 20; i++) begin
      reinit = (i % 5 == 0);
      stepCycle();
    end
    reinit = 1'b0;
    checkOutput("fail_sticky", phyFail, 1);
    pulseReset(1);

    // Random soak with occasional lock drops, reinit requests and async resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) pll   = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 59) == 0) dcm   = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 29) == 0) done0 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) done1 = ($urandom_range(0, 3) != 0);
      reinit = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 299) == 0) pulseReset($urandom_range(0, 2));
      else                             stepCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
